// File: rtl/sram_port_arbiter_if.sv
// Bundle of the signals between the SRAM port arbiter, its two requesters
// (instruction fetch and load/store) and the single-port SRAM.
// The slave modport is the arbiter's view; master is the view of whatever
// drives the requests and models the SRAM.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 32
);
    // Instruction-fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [WORD_W-1:0] if_rdata_o;

    // Load/store port
    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [WORD_W-1:0] ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [WORD_W-1:0] ls_rdata_o;

    // SRAM port
    logic              sram_en_o;
    logic              sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [WORD_W-1:0] sram_din_o;
    logic [WORD_W-1:0] sram_dout_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output sram_en_o, sram_we_o, sram_addr_o, sram_din_o,
        input  sram_dout_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  sram_en_o, sram_we_o, sram_addr_o, sram_din_o,
        output sram_dout_i
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port, read-first SRAM.
// Instruction fetch and load/store share the port; conflicts alternate
// using a last-owner register. Grants are combinational so a requester can
// be served in the same cycle it asks. Read responses are steered back to
// their owner by a tag shift register as deep as the SRAM read latency, so
// a new access can be granted every cycle with no stall.
module sram_port_arbiter #(
    parameter int ADDR_W = 11,   // SRAM word-address width
    parameter int RD_LAT = 2,    // SRAM read latency in cycles, 1..4
    parameter int WORD_W = 32    // SRAM word width
) (
    input  logic              CLK,
    input  logic              nRST,
    sram_port_arbiter_if.slave bus
);

    // Who was granted most recently; IF after reset so the first conflict
    // goes to load/store.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    owner_t            last_owner_reg;
    owner_t            last_owner_next;

    logic              ls_wins;
    logic              if_gnt;
    logic              ls_gnt;
    logic              any_gnt;

    logic [ADDR_W-1:0] addr_hold_reg;
    logic [WORD_W-1:0] din_hold_reg;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_W-1:0] sram_din;

    // Tag pipeline: valid marks a read, owner is 1 for load/store, 0 for IF.
    logic              push_valid;
    logic              push_owner;
    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_owner_reg;

    // Arbitration: a lone requester wins outright; on conflict the side that
    // was not granted last wins. Grants are suppressed while in reset.
    always_comb begin
        ls_wins         = 1'b0;
        last_owner_next = last_owner_reg;
        if (bus.ls_req_i && bus.if_req_i) begin
            ls_wins = (last_owner_reg == OWN_IF);
        end else begin
            ls_wins = bus.ls_req_i;
        end
        ls_gnt  = nRST & ls_wins;
        if_gnt  = nRST & bus.if_req_i & ~ls_wins;
        any_gnt = ls_gnt | if_gnt;
        if (ls_gnt) begin
            last_owner_next = OWN_LS;
        end else if (if_gnt) begin
            last_owner_next = OWN_IF;
        end
    end

    // SRAM port drive: winner's address/data on a grant, otherwise hold the
    // last granted values so the address bus does not toggle when idle.
    always_comb begin
        sram_addr  = addr_hold_reg;
        sram_din   = din_hold_reg;
        push_valid = any_gnt & ~(ls_gnt & bus.ls_we_i);
        push_owner = ls_gnt;
        if (ls_gnt) begin
            sram_addr = bus.ls_addr_i;
            sram_din  = bus.ls_wdata_i;
        end else if (if_gnt) begin
            sram_addr = bus.if_addr_i;
        end
    end

    // Last owner and held SRAM address/data registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_owner_reg <= OWN_IF;
            addr_hold_reg  <= '0;
            din_hold_reg   <= '0;
        end else begin
            last_owner_reg <= last_owner_next;
            if (any_gnt) begin
                addr_hold_reg <= sram_addr;
            end
            if (ls_gnt) begin
                din_hold_reg <= sram_din;
            end
        end
    end

    // Tag shift register: stage 0 takes this cycle's grant, the last stage
    // lines up with the SRAM returning that read's data.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
            // One tag stage; cleared on reset so in-flight reads are dropped.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_owner_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    tag_valid_reg[gi] <= push_valid;
                    tag_owner_reg[gi] <= push_owner;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[(gi == 0) ? 0 : gi-1];
                    tag_owner_reg[gi] <= tag_owner_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.sram_en_o   = any_gnt;
    assign bus.sram_we_o   = ls_gnt & bus.ls_we_i;
    assign bus.sram_addr_o = sram_addr;
    assign bus.sram_din_o  = sram_din;

    assign bus.if_rvalid_o = tag_valid_reg[RD_LAT-1] & ~tag_owner_reg[RD_LAT-1];
    assign bus.ls_rvalid_o = tag_valid_reg[RD_LAT-1] &  tag_owner_reg[RD_LAT-1];

    // Read data goes straight through; rvalid says whose it is.
    assign bus.if_rdata_o  = bus.sram_dout_i;
    assign bus.ls_rdata_o  = bus.sram_dout_i;

endmodule
